mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide execute unit, sitting beside the single-cycle ALU in the datapath EX stage.
- Owns the architectural HI/LO registers and accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO from the controller through a Start/Busy handshake.
- The controller stalls dependent HI/LO reads (MFHI/MFLO) and further MD ops while Busy is high.

Parameters:
- MULT_CYCLES, 5, cycles Busy stays high for MULT/MULTU (minimum 1).
- DIV_CYCLES, 10, cycles Busy stays high for DIV/DIVU (minimum 1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- A  input  32  operand rs (dividend / multiplicand / MTHI-MTLO source).
- B  input  32  operand rt (divisor / multiplier).
- MDOp  input  3  operation: 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; 000 and 111 are no-op.
- Start  input  1  one-cycle request qualifying MDOp/A/B.
- Busy  output  1  high while a multi-cycle op is in flight.
- HI  output  32  HI register.
- LO  output  32  LO register.
- Flush  input  1  present only with MD_FLUSH_EN; aborts the in-flight op.

Behaviour:
- Reset (synchronous, active-high) has priority over everything: HI=0, LO=0, Busy=0, counter=0, FSM=IDLE. Reset mid-operation discards the pending result.
- The FSM has two states, IDLE and RUN.
- IDLE, Start=1, MDOp in {MULT, MULTU, DIV, DIVU}:
  - Latch the op and the computed result into pending registers on this edge.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN. Busy=1 from the next cycle.
- IDLE, Start=1, MDOp=MTHI: HI<=A on this edge. Busy stays 0. MTLO behaves the same way for LO.
- IDLE, Start=1, MDOp no-op: nothing happens.
- RUN:
  - The counter decrements every cycle.
  - When the counter reaches 1, commit the pending HI/LO on that edge, set Busy=0 and return to IDLE.
  - With MULT_CYCLES=5, Start at edge t gives Busy high for edges t+1..t+5 and new HI/LO visible after edge t+5.
- Start while Busy=1 is ignored, including MTHI/MTLO. The controller must not issue it.
- Start in the cycle Busy drops is legal, because the FSM is already in IDLE.
- HI/LO hold their old values throughout RUN. They update only at commit.
- MULT: signed 32x32 to 64-bit product; HI=product[63:32], LO=product[31:0].
- MULTU: the same as MULT, with unsigned operands.
- DIV: signed division, quotient truncated toward zero, remainder takes the sign of the dividend. LO=quotient, HI=remainder.
- DIV overflow case, 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- DIVU: unsigned division; LO=quotient, HI=remainder.
- Divide by zero (B=0, DIV or DIVU): full latency with Busy asserted, HI/LO left unchanged at commit.

Optional Feature:
- Macro name: MD_FLUSH_EN.
- When defined, the Flush port exists. Flush=1 in RUN returns to IDLE on that edge with Busy=0 and HI/LO unchanged, so the pending result is dropped.
- Flush=1 together with Start in IDLE suppresses the Start, including MTHI/MTLO.
- Reset still has priority over Flush.
- When not defined, there is no Flush port and an in-flight op always completes.

Test Plan:
- Reset: assert reset for 2 cycles mid-MULT -> Busy=0, HI=0, LO=0 next cycle, and no late commit.
- MULT: A=0xFFFFFFFE (-2), B=3 -> Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Issue MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV: A=0xFFFFFFF9 (-7), B=2 -> Busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Issue DIVU A=7, B=2 -> LO=3, HI=1.
- Edge divides: DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU with B=0 after HI=0x11, LO=0x22 -> full 10-cycle Busy, HI=0x11, LO=0x22 unchanged.
- Moves and ignore rule: MTHI A=0xDEADBEEF -> HI=0xDEADBEEF next cycle, Busy never high. A Start MTLO issued mid-MULT is ignored, and LO equals the MULT result. A back-to-back Start on the cycle Busy falls is accepted.
- With MD_FLUSH_EN: start DIV, pulse Flush on the 4th Busy cycle -> Busy=0 next cycle, HI/LO keep their prior values, and a following MULT runs its full 5 cycles correctly.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit that owns the HI/LO registers, with a Start/Busy handshake.
// Optional macro MD_FLUSH_EN adds a Flush input that aborts an in-flight op.
`timescale 1ns/1ps

// state | meaning
// IDLE  | waiting for Start; MTHI/MTLO write HI/LO immediately
// RUN   | result pending; counter counts down to commit
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDOp,
  input  logic        Start,
`ifdef MD_FLUSH_EN
  input  logic        Flush,
`endif
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt;
  logic [31:0]   pend_hi, pend_lo;
  logic          pend_wr;
  logic          flush;

`ifdef MD_FLUSH_EN
  assign flush = Flush;
`else
  assign flush = 1'b0;
`endif

  logic [63:0] prod_s, prod_u;
  logic [31:0] b_nz, mag_a, mag_b, sq, sr, q_s, r_s, uq, ur;

  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'b0, A} * {32'b0, B};

  // Divisor forced non-zero so the divider never sees 0; the write is suppressed instead.
  assign b_nz  = (B == 32'd0) ? 32'd1 : B;
  assign mag_a = A[31] ? (~A + 32'd1) : A;
  assign mag_b = b_nz[31] ? (~b_nz + 32'd1) : b_nz;
  assign sq    = mag_a / mag_b;
  assign sr    = mag_a % mag_b;
  assign q_s   = (A[31] ^ b_nz[31]) ? (~sq + 32'd1) : sq;
  assign r_s   = A[31] ? (~sr + 32'd1) : sr;
  assign uq    = A / b_nz;
  assign ur    = A % b_nz;

  logic [31:0] res_hi, res_lo;
  logic        res_wr, res_div;

  always_comb begin
    res_hi  = prod_s[63:32];
    res_lo  = prod_s[31:0];
    res_wr  = 1'b1;
    res_div = 1'b0;
    case (MDOp)
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      OP_DIV: begin
        res_hi  = r_s;
        res_lo  = q_s;
        res_wr  = (B != 32'd0);
        res_div = 1'b1;
      end
      OP_DIVU: begin
        res_hi  = ur;
        res_lo  = uq;
        res_wr  = (B != 32'd0);
        res_div = 1'b1;
      end
      default: ;
    endcase
  end

  logic load, commit, wr_mthi, wr_mtlo;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    commit  = 1'b0;
    wr_mthi = 1'b0;
    wr_mtlo = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start && !flush) begin
          case (MDOp)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              load    = 1'b1;
              state_d = RUN;
            end
            OP_MTHI: wr_mthi = 1'b1;
            OP_MTLO: wr_mtlo = 1'b1;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else if (cnt == CNT_ONE) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else if (load) begin
      cnt     <= res_div ? DIV_LOAD : MULT_LOAD;
      pend_hi <= res_hi;
      pend_lo <= res_lo;
      pend_wr <= res_wr;
    end else if (state_q == RUN) begin
      cnt <= (flush || commit) ? '0 : cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      HI <= '0;
      LO <= '0;
    end else if (commit) begin
      if (pend_wr) begin
        HI <= pend_hi;
        LO <= pend_lo;
      end
    end else begin
      if (wr_mthi) HI <= A;
      if (wr_mtlo) LO <= A;
    end
  end

  assign Busy = (state_q == RUN);

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO pushed at issue, popped when Busy falls.
`timescale 1ns/1ps

module tb_mult_div_unit;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [2:0]  MDOp;
  logic        Start;
  logic        Busy;
  logic [31:0] HI, LO;
`ifdef MD_FLUSH_EN
  logic        Flush;
`endif

  int total = 0;
  int bad   = 0;
  logic [63:0] sb[$];
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk  (clk),
    .reset(reset),
    .A    (A),
    .B    (B),
    .MDOp (MDOp),
    .Start(Start),
`ifdef MD_FLUSH_EN
    .Flush(Flush),
`endif
    .Busy (Busy),
    .HI   (HI),
    .LO   (LO)
  );

  // Reference model, written in 64-bit integer arithmetic.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, b,
                                        input logic [31:0] hi, lo);
    longint sa, sbv, q, r, p;
    logic [63:0] pu;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (op)
      OP_MULT:  begin p = sa * sbv; return p; end
      OP_MULTU: begin pu = 64'(a) * 64'(b); return pu; end
      OP_DIV: begin
        if (b == 32'd0) return {hi, lo};
        q = sa / sbv;
        r = sa % sbv;
        return {r[31:0], q[31:0]};
      end
      OP_DIVU: begin
        if (b == 32'd0) return {hi, lo};
        return {a % b, a / b};
      end
      default: return {hi, lo};
    endcase
  endfunction

  // Called at a negedge; leaves Start low at the following negedge.
  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; MDOp = op; A = a; B = b;
    @(negedge clk);
    Start = 1'b0; MDOp = OP_NOP;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (Busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; Start = 1'b0; MDOp = OP_NOP; A = '0; B = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    total++; if ({Busy, HI, LO} !== 65'd0) begin bad++; $display("FAIL reset_init: got busy=%b hi=%h lo=%h want 0/0/0", Busy, HI, LO); end
    m_hi = '0; m_lo = '0;
    drive(OP_MULT, 32'hFFFFFFFE, 32'd3);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++; if ({Busy, HI, LO} !== 65'd0) begin bad++; $display("FAIL reset_mid: got busy=%b hi=%h lo=%h want 0/0/0", Busy, HI, LO); end
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    total++; if ({Busy, HI, LO} !== 65'd0) begin bad++; $display("FAIL reset_late_commit: got busy=%b hi=%h lo=%h want 0/0/0", Busy, HI, LO); end
  endtask

  task automatic test_mult();
    logic [2:0]  ops[2] = '{OP_MULT, OP_MULTU};
    logic [63:0] exp[2] = '{64'hFFFFFFFF_FFFFFFFA, 64'h00000002_FFFFFFFA};
    for (int i = 0; i < 2; i++) begin
      int n;
      logic [63:0] e;
      sb.push_back(exp[i]);
      drive(ops[i], 32'hFFFFFFFE, 32'd3);
      total++; if ({HI, LO} !== {m_hi, m_lo}) begin bad++; $display("FAIL mult_hold[%0d]: got %h_%h want %h_%h", i, HI, LO, m_hi, m_lo); end
      wait_done(n);
      total++; if (n != 5) begin bad++; $display("FAIL mult_busy[%0d]: got %0d cycles want 5", i, n); end
      e = sb.pop_front();
      total++; if ({HI, LO} !== e) begin bad++; $display("FAIL mult_result[%0d]: got %h_%h want %h", i, HI, LO, e); end
      m_hi = e[63:32]; m_lo = e[31:0];
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops[2] = '{OP_DIV, OP_DIVU};
    logic [31:0] as[2]  = '{32'hFFFFFFF9, 32'd7};
    logic [63:0] exp[2] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_00000003};
    for (int i = 0; i < 2; i++) begin
      int n;
      logic [63:0] e;
      sb.push_back(exp[i]);
      drive(ops[i], as[i], 32'd2);
      wait_done(n);
      total++; if (n != 10) begin bad++; $display("FAIL div_busy[%0d]: got %0d cycles want 10", i, n); end
      e = sb.pop_front();
      total++; if ({HI, LO} !== e) begin bad++; $display("FAIL div_result[%0d]: got %h_%h want %h", i, HI, LO, e); end
      m_hi = e[63:32]; m_lo = e[31:0];
    end
  endtask

  task automatic test_edge_div();
    int n;
    logic [63:0] e;
    sb.push_back(64'h00000000_80000000);
    drive(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(n);
    e = sb.pop_front();
    total++; if ({HI, LO} !== e) begin bad++; $display("FAIL div_overflow: got %h_%h want %h", HI, LO, e); end
    drive(OP_MTHI, 32'h11, 32'd0);
    drive(OP_MTLO, 32'h22, 32'd0);
    m_hi = 32'h11; m_lo = 32'h22;
    sb.push_back({m_hi, m_lo});
    drive(OP_DIVU, 32'd5, 32'd0);
    wait_done(n);
    total++; if (n != 10) begin bad++; $display("FAIL div0_busy: got %0d cycles want 10", n); end
    e = sb.pop_front();
    total++; if ({HI, LO} !== e) begin bad++; $display("FAIL div0_result: got %h_%h want %h", HI, LO, e); end
  endtask

  task automatic test_moves();
    int n;
    logic [63:0] e;
    drive(OP_MTHI, 32'hDEADBEEF, 32'd0);
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL mthi_busy: got %b want 0", Busy); end
    total++; if ({HI, LO} !== {32'hDEADBEEF, m_lo}) begin bad++; $display("FAIL mthi_value: got %h_%h want deadbeef_%h", HI, LO, m_lo); end
    m_hi = 32'hDEADBEEF;
    sb.push_back(64'h00000000_0000002A);
    drive(OP_MULT, 32'd7, 32'd6);
    @(negedge clk);
    drive(OP_MTLO, 32'h55, 32'd0);
    wait_done(n);
    total++; if (n != 3) begin bad++; $display("FAIL ignore_busy: got %0d remaining cycles want 3", n); end
    e = sb.pop_front();
    total++; if ({HI, LO} !== e) begin bad++; $display("FAIL ignore_mtlo: got %h_%h want %h", HI, LO, e); end
    m_hi = e[63:32]; m_lo = e[31:0];
  endtask

  task automatic test_back_to_back();
    int n;
    logic [63:0] e;
    sb.push_back(64'h00000001_00000000);
    drive(OP_MULTU, 32'h10000, 32'h10000);
    wait_done(n);
    e = sb.pop_front();
    total++; if ({HI, LO} !== e) begin bad++; $display("FAIL b2b_first: got %h_%h want %h", HI, LO, e); end
    m_hi = e[63:32]; m_lo = e[31:0];
    sb.push_back(64'h00000002_0000000E);
    drive(OP_DIVU, 32'd100, 32'd7);
    wait_done(n);
    total++; if (n != 10) begin bad++; $display("FAIL b2b_busy: got %0d cycles want 10", n); end
    e = sb.pop_front();
    total++; if ({HI, LO} !== e) begin bad++; $display("FAIL b2b_second: got %h_%h want %h", HI, LO, e); end
    m_hi = e[63:32]; m_lo = e[31:0];
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      int n, want_n;
      logic [2:0]  op;
      logic [31:0] a, b;
      logic [63:0] e;
      op = 3'($urandom_range(1, 4));
      a  = $urandom;
      b  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if (i == 0) b = 32'd0;
      want_n = (op == OP_MULT || op == OP_MULTU) ? 5 : 10;
      sb.push_back(model(op, a, b, m_hi, m_lo));
      drive(op, a, b);
      wait_done(n);
      total++; if (n != want_n) begin bad++; $display("FAIL rand_busy[%0d]: op=%0d got %0d cycles want %0d", i, op, n, want_n); end
      e = sb.pop_front();
      total++; if ({HI, LO} !== e) begin bad++; $display("FAIL rand_result[%0d]: op=%0d a=%h b=%h got %h_%h want %h", i, op, a, b, HI, LO, e); end
      m_hi = e[63:32]; m_lo = e[31:0];
    end
  endtask

`ifdef MD_FLUSH_EN
  task automatic test_flush();
    int n;
    logic [63:0] e;
    drive(OP_DIV, 32'd100, 32'd3);
    repeat (3) @(negedge clk);
    Flush = 1'b1;
    @(negedge clk);
    Flush = 1'b0;
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL flush_busy: got %b want 0", Busy); end
    total++; if ({HI, LO} !== {m_hi, m_lo}) begin bad++; $display("FAIL flush_hold: got %h_%h want %h_%h", HI, LO, m_hi, m_lo); end
    Flush = 1'b1;
    drive(OP_MTHI, 32'hABCD, 32'd0);
    Flush = 1'b0;
    total++; if ({Busy, HI} !== {1'b0, m_hi}) begin bad++; $display("FAIL flush_start: got busy=%b hi=%h want 0/%h", Busy, HI, m_hi); end
    sb.push_back(64'h00000000_0000002A);
    drive(OP_MULT, 32'd7, 32'd6);
    wait_done(n);
    total++; if (n != 5) begin bad++; $display("FAIL flush_after_busy: got %0d cycles want 5", n); end
    e = sb.pop_front();
    total++; if ({HI, LO} !== e) begin bad++; $display("FAIL flush_after_result: got %h_%h want %h", HI, LO, e); end
    m_hi = e[63:32]; m_lo = e[31:0];
  endtask
`endif

  initial begin
`ifdef MD_FLUSH_EN
    Flush = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_edge_div();
    test_moves();
    test_back_to_back();
    test_random();
`ifdef MD_FLUSH_EN
    test_flush();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
